// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited in-order requests, prefetch queue, redirect flush.
// Optional combinational response-to-decode bypass is enabled by defining FETCH_BYPASS_EN.
module fetch_unit #(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter int            DEPTH    = 4,
  parameter int            PC_STEP  = 1,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ready,
  input  logic          imem_rvalid,
  input  logic [DW-1:0] imem_rdata,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [DW-1:0] inst_data,
  output logic [AW-1:0] inst_pc
);
  localparam int            CW      = $clog2(DEPTH + 1);
  localparam int            PW      = $clog2(DEPTH);
  localparam logic [AW-1:0] STEP    = AW'(PC_STEP);
  localparam logic [CW:0]   CREDITS = (CW + 1)'(DEPTH);

  logic [AW-1:0] pc_q;
  logic [AW-1:0] resp_pc;
  logic [AW-1:0] pc_mem   [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;

  logic accept;
  logic resp_keep;
  logic q_empty;
  logic push;
  logic q_pop;
  logic bypass_take;

  assign imem_addr = pc_q;
  assign q_empty   = (count == '0);
  // Every in-flight request owns a queue slot, so the queue can never overflow.
  assign imem_req  = rst_n & ~redirect_valid
                   & (({1'b0, outstanding} + {1'b0, count}) < CREDITS);
  assign accept    = imem_req & imem_ready;
  assign resp_keep = imem_rvalid & (drop == '0) & ~redirect_valid;
  assign push      = resp_keep & ~bypass_take;
  assign q_pop     = inst_valid & inst_ready & ~q_empty;

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    inst_valid  = ~q_empty;
    inst_pc     = pc_mem[rd_ptr];
    inst_data   = data_mem[rd_ptr];
    bypass_take = 1'b0;
`ifdef FETCH_BYPASS_EN
    if (q_empty && resp_keep) begin
      inst_valid  = 1'b1;
      inst_pc     = resp_pc;
      inst_data   = imem_rdata;
      bypass_take = inst_ready;
    end
`endif
    if (!inst_valid) begin
      inst_pc   = '0;
      inst_data = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      resp_pc     <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(imem_rvalid);
      if (redirect_valid) begin
        pc_q    <= redirect_pc;
        resp_pc <= redirect_pc;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        // Everything still in flight after this edge is stale, including older drops.
        drop    <= outstanding - CW'(imem_rvalid);
      end else begin
        if (accept)    pc_q    <= pc_q + STEP;
        if (resp_keep) resp_pc <= resp_pc + STEP;
        if (push)      wr_ptr  <= wr_ptr + PW'(1);
        if (q_pop)     rd_ptr  <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(q_pop);
        if (imem_rvalid && drop != '0) drop <= drop - CW'(1);
      end
    end
  end

  // NOTE: queue storage is not reset; count and pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= resp_pc;
      data_mem[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the RISC-V core: the next generation of the fixed `pc + 1` program counter. It issues word-addressed requests to an instruction memory with variable latency and keeps several requests in flight. Returned instructions are buffered with their PC in an in-order prefetch queue and handed to decode through a valid/ready handshake. A single-cycle redirect from execute (taken branch or jump) flushes the queue and discards stale in-flight responses.

## Interface
Parameters:
- `AW`, 32, PC / instruction-address width.
- `DW`, 32, instruction width.
- `DEPTH`, 4, prefetch-queue entries and maximum outstanding requests (credit pool); power of two, ≥2.
- `PC_STEP`, 1, PC increment per fetched instruction (word addressing).
- `RESET_PC`, 0, PC loaded at reset.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  AW  fetch address; equals the internal `pc_q`.
- `imem_ready`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  response valid; responses return in request order, latency ≥1.
- `imem_rdata`  in  DW  response instruction.
- `redirect_valid`  in  1  redirect fetch this cycle.
- `redirect_pc`  in  AW  redirect target.
- `inst_valid`  out  1  instruction available to decode.
- `inst_ready`  in  1  decode accepts the instruction.
- `inst_data`  out  DW  instruction at queue head.
- `inst_pc`  out  AW  PC of `inst_data`.

## Operation
- State: `pc_q` (next request address), `resp_pc` (PC of the next expected response), queue of `DEPTH` {pc, data} entries, `outstanding` and `drop` counters of width clog2(DEPTH+1).
- Request: `imem_req = rst_n & ~redirect_valid & (outstanding + count < DEPTH)`. Accept is `imem_req & imem_ready`. On accept: `pc_q += PC_STEP`, `outstanding++`.
- Response: `imem_rvalid` decrements `outstanding`. If `drop > 0`, the response is discarded and `drop--`. Otherwise {`resp_pc`, `imem_rdata`} is pushed and `resp_pc += PC_STEP`.
- Credit rule: the queue can never overflow. A response with no free entry is a protocol error; behaviour is undefined.
- Pop: `inst_valid & inst_ready` removes the head entry.
- Redirect (edge with `redirect_valid=1`): `pc_q` and `resp_pc` load `redirect_pc`.
  - Queue is emptied.
  - `drop` loads `outstanding` minus 1 if `imem_rvalid` is high this cycle (the response arriving this cycle is discarded); any prior `drop` is subsumed.
  - A pop handshake in the redirect cycle completes normally.
- `inst_data` and `inst_pc` are driven 0 whenever `inst_valid=0`.
- Arithmetic: all PC adds wrap modulo 2^AW; `0xFFFF_FFFF + 1 = 0`.

## Timing
- Reset values (edge with `rst_n=0`):
  - `pc_q=RESET_PC`, `resp_pc=RESET_PC`, queue empty, `outstanding=0`, `drop=0`.
  - Outputs: `imem_req=0`, `imem_addr=RESET_PC`, `inst_valid=0`, `inst_data=0`, `inst_pc=0`.
  - The instruction memory is reset by the same `rst_n`, so it returns no pre-reset responses.
- First request is issued in the first cycle with `rst_n=1`.
- Request accepted in cycle N with memory latency L gives `rvalid` in cycle N+L. The entry is written at the end of N+L and `inst_valid=1` in N+L+1.
- Throughput is 1 instruction/cycle sustained when `DEPTH ≥ L+2`.
- Full: `imem_req` drops in the same cycle that `outstanding + count` reaches `DEPTH`.
- Empty: `inst_valid=0` the cycle after the last pop.
- Push and pop in the same cycle: `count` is unchanged, order is preserved.
- Redirect: `imem_req=0` in the redirect cycle. The first request to `redirect_pc` is issued the next cycle. No pre-redirect instruction is presented after the redirect edge.

## Configuration
- `FETCH_BYPASS_EN` defined: when the queue is empty, the response is non-dropped, and there is no redirect, `imem_rdata`/`resp_pc` appear combinationally on `inst_*` with `inst_valid=1` in cycle N+L.
  - If `inst_ready=1` the entry is consumed and not written.
  - Otherwise it is written normally.
  - Latency drops by one cycle.
- Undefined: no combinational path from `imem_*` to `inst_*`; latency as in Timing.

## Test plan
- Reset and streaming: release reset, memory L=1 always ready, `inst_ready=1`.
  - Expect requests to 0,1,2,3,…
  - Expect `inst_pc` 0,1,2,… on consecutive cycles from cycle 2 (cycle 1 with bypass), `inst_data` matching memory.
- Back-pressure: `inst_ready=0` for 10 cycles, DEPTH=4, L=1.
  - Expect exactly 4 requests, then `imem_req=0`.
  - After release, PCs 0–3 delivered in order with no loss or duplicates.
- Redirect with in-flight: L=3 and 3 requests outstanding (PCs 4,5,6); pulse `redirect_valid` with `redirect_pc=0x40`.
  - Expect the three stale responses discarded and `imem_req=0` in the redirect cycle.
  - Next `inst_pc` is 0x40 followed by 0x41.
- Redirect coinciding with a response and a pop: all three in the same cycle.
  - Expect the popped instruction delivered and the coincident response dropped.
  - `drop` equals `outstanding−1`.
- Wrap-around: `redirect_pc=0xFFFF_FFFE`, AW=32.
  - Expect `inst_pc` sequence 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
- Mid-operation reset: assert `rst_n=0` for one cycle while the queue is 3/4 full.
  - Expect all outputs at reset values the next cycle and fetch restarting at `RESET_PC`.
